// File: rtl/mem_loader_pkg.sv
// Shared FSM encoding and default sizes for the operand-memory loader.
package mem_loader_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_loader_csum.sv
// Modular running sum of the words written by one load; cleared when a load starts.
module mem_loader_csum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into consecutive operand-memory words from a base address.
// Optional write checksum is built when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_acc;
  logic              hs;

  // in_ready_q is high exactly while in LOAD
  assign start_acc = start && (state_q == IDLE);
  assign hs        = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_acc) state_d = (count == '0) ? DONE : LOAD;
      LOAD:  if (hs && (rem_q == CNT_W'(1))) state_d = FLUSH;
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, remaining count, memory port and status outputs
  always_comb begin
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start_acc) begin
      ptr_d = base_addr;
      rem_d = count;
    end else if (hs) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_q;
      mem_wdata_d = in_data;
      ptr_d       = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
      rem_d       = rem_q - CNT_W'(1);
    end
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  mem_loader_csum #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .add_en  (hs),
    .add_data(in_data),
    .sum     (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: the driver queues expected writes, a monitor checks them.
module tb_mem_loader;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned DEP = 8;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, checksum;

  typedef struct {
    int addr;
    int data;
    int csum;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  last_addr = 0;
  int  last_data = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_done = 0;
  int  exp_done = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue; idle port must hold
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = 0;
      last_data = 0;
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_we), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
          check("wr_csum", 32'(checksum), 32'(mon_e.csum));
          last_addr = mon_e.addr;
          last_data = mon_e.data;
        end
      end else begin
        check("hold_addr", 32'(mem_addr), 32'(last_addr));
        check("hold_data", 32'(mem_wdata), 32'(last_data));
      end
      if (done) begin
        n_done++;
        check("busy_with_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // gap: 0 back-to-back, 1 random gaps, 2 alternate cycles; restart_at/abort_at < 0 disable
  task automatic run_load(input int b, input logic [7:0] words[$], input int gap,
                          input int restart_at, input int abort_at);
    int  c = words.size();
    int  n_feed;
    int  sum = 0;
    int  i = 0;
    int  guard = 0;
    bit  restarted = 1'b0;
    wr_t e;
    for (int k = 0; k < c; k++) begin
      sum    = (sum + int'(words[k])) % 256;
      e.addr = (b + k) % DEP;
      e.data = int'(words[k]);
      e.csum = CSUM_ON ? sum : 0;
      exp_q.push_back(e);
    end
    n_feed = (abort_at >= 0) ? abort_at : c;

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    count     = (AW + 1)'(c);

    if (c == 0) begin
      @(negedge clk);
      start = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd1);
      check("zero_csum", 32'(checksum), 32'd0);
      @(negedge clk);
      check("zero_done_clr", 32'(done), 32'd0);
      check("zero_busy_clr", 32'(busy), 32'd0);
      exp_done++;
      return;
    end

    while (i < n_feed) begin
      @(negedge clk);
      start = (restart_at >= 0) && (i == restart_at) && !restarted;
      if (start) begin
        base_addr = AW'(3);
        count     = (AW + 1)'(2);
        restarted = 1'b1;
      end else begin
        base_addr = AW'($urandom);
        count     = (AW + 1)'($urandom_range(0, DEP));
      end
      if ((gap == 1 && $urandom_range(0, 1) == 1) || (gap == 2 && (guard % 2) == 1)) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = words[i];
      end
      check("in_ready_load", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) i++;
      guard++;
      if (guard > 200) begin
        check("load_timeout", 32'(i), 32'(n_feed));
        break;
      end
    end

    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;

    if (abort_at >= 0) begin
      #1 rst = 1'b0;
      #1 check_all_zero("abort");
      check("abort_pending", 32'(exp_q.size()), 32'(c - abort_at));
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      return;
    end

    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_no_done", 32'(done), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_csum", 32'(checksum), 32'(CSUM_ON ? sum : 0));
    @(negedge clk);
    check("done_clr", 32'(done), 32'd0);
    check("busy_clr", 32'(busy), 32'd0);
    check("drained", 32'(exp_q.size()), 32'd0);
    exp_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w[$];

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Stream presented while idle must be ignored
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_we", 32'(mem_we), 32'd0);
      check("idle_no_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0, w, 0, -1, -1);

    w = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_load(6, w, 2, -1, -1);

    w.delete();
    run_load(5, w, 0, -1, -1);

    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load(1, w, 0, 2, -1);

    w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_load(0, w, 0, -1, 2);

    check_all_zero("post_abort");
    w = '{8'h7F};
    run_load(2, w, 0, -1, -1);

    for (int t = 0; t < 20; t++) begin
      int n = $urandom_range(0, DEP);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back(8'($urandom));
      run_load($urandom_range(0, DEP - 1), w, $urandom_range(0, 1), -1, -1);
    end

    repeat (3) @(negedge clk);
    check("done_count", 32'(n_done), 32'(exp_done));
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Operand loader for the lab datapath's 8x8 operand memory, i.e. the writer side of the memory that the datapath reads through its two read addresses. It accepts a stream of bytes over a valid/ready handshake and writes them into consecutive memory locations starting at a programmable base address, wrapping modulo the depth. When the requested count has been written, it pulses `done`, and the datapath may then be released from reset to compute.

## Interface
- DATA_W, 8, width of each memory word
- ADDR_W, 3, memory address width
- DEPTH, 8, number of memory words (2**ADDR_W)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load; ignored unless idle
- base_addr  input  ADDR_W  first write address; sampled on accepted `start`
- count  input  ADDR_W+1  number of words to write (0..DEPTH); sampled on accepted `start`
- in_data  input  DATA_W  stream data
- in_valid  input  1  stream data valid
- in_ready  output  1  loader can accept a word this cycle
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  memory write address, registered
- mem_wdata  output  DATA_W  memory write data, registered
- busy  output  1  high from accepted `start` until `done` pulse inclusive
- done  output  1  one-cycle completion pulse
- checksum  output  DATA_W  modular sum of words written in current/last load (see Configuration)

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE: `in_ready`=0. `start`=1 latches `base_addr` into the write pointer and `count` into the remaining counter, then moves to LOAD. If `count`=0, it moves directly to DONE and no write occurs.
- LOAD: `in_ready`=1. Handshake = `in_valid && in_ready`. On each handshake, the next cycle drives `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=`in_data`. The pointer then increments modulo DEPTH (7 wraps to 0) and the remaining counter decrements. A handshake with remaining=1 moves to FLUSH.
- FLUSH: `in_ready`=0. The last write is visible on the memory port during this cycle. Next state: DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1. Next state: IDLE.
- `mem_we` is 0 in every cycle not following a handshake. `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.
- `start` while not IDLE: ignored, with no effect on pointer or count.
- `in_valid` outside LOAD: ignored. The word is not consumed.
- `in_valid` gaps in LOAD: the FSM waits indefinitely with no timeout.
- A count that wraps past the base address, e.g. base=6 with count=4, writes addresses 6, 7, 0, 1.

## Timing
- Reset (rst=0, async): state=IDLE. All outputs are 0: `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `checksum`.
- Reset asserted mid-load: the load aborts immediately. Writes already issued stand and no further `mem_we` occurs. After release, the loader is in IDLE.
- Latency: handshake at edge N gives `mem_we` high in the cycle after edge N.
- The last handshake is at edge N. FLUSH holds `mem_we`. `done` is high in the cycle after edge N+1.
- Throughput: 1 word per clock when `in_valid` is held high.
- Best case, `count` words need `count`+3 cycles from `start` to the end of the `done` cycle.
- `count`=0: `busy` and `done` are both high in the single cycle following `start`.

## Configuration
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined: `checksum` clears to 0 on accepted `start`. Each written word is added modulo 2**DATA_W in the same cycle it appears on `mem_wdata`. The value is held after DONE until the next `start`.
- Undefined: `checksum` is tied to 0 and no accumulator is built.

## Structure
- Shared package `mem_loader_pkg`: FSM state enum (IDLE, LOAD, FLUSH, DONE) and default DATA_W/ADDR_W/DEPTH constants.
- Optional sub-module `mem_loader_csum`: the accumulator, instantiated only under MEM_LOADER_CHECKSUM_EN. Everything else lives in one module.

## Test plan
- Reset then idle: all outputs are 0. `in_valid`=1 with data 0xAA gives no `mem_we`.
- base=0, count=8, stream 0x01..0x08 back-to-back: writes addr 0..7 with data 0x01..0x08 on consecutive cycles; one `done` pulse; checksum=0x24 when enabled.
- base=6, count=4, data 0x10, 0x20, 0x30, 0x40 with one-cycle `in_valid` gaps: writes addr 6, 7, 0, 1 in order; no write during gaps.
- count=0: no `mem_we`; `done` pulse one cycle after `start`.
- `start` pulsed during LOAD with base=3: ignored; addresses continue from the original pointer.
- rst=0 after 2 of 5 words: outputs drop to 0 asynchronously. A new `start` with base=2, count=1 and data 0x7F writes 0x7F at addr 2.
